fft_sdf_sequencer: RTL and testbench

//  Control sequencer for the radix-2 single-path delay-feedback FFT pipeline. Tracks the

---
 rtl/fft_sdf_sequencer.sv | 166 ++++++++++++++++
 tb/tb_fft_sdf_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fft_sdf_sequencer.sv
// Control sequencer for a radix-2 single-path delay-feedback FFT pipeline: sample indexing,
// shared stage enable, per-stage butterfly/bypass and twiddle addressing, output framing, flush drain.
//
// state | meaning
// IDLE  | waiting for a frame start; pipeline frozen
// FILL  | first frame entering; pipe not yet producing valid output
// RUN   | steady state; every accepted sample yields one output sample
// DRAIN | zero-fill for FFT_N-1 cycles to push the last frame out
module fft_sdf_sequencer #(
    parameter int FFT_N = 1024,
    parameter int LOG2N = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 flush,
    output logic                 enable,
    output logic [LOG2N-1:0]     ctrl,
    output logic [16*LOG2N-1:0]  address,
    output logic                 zero_fill,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic                 sop_err,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    localparam logic [LOG2N-1:0] LAST     = LOG2N'(FFT_N - 1);
    localparam logic [LOG2N-1:0] PRE_LAST = LOG2N'(FFT_N - 2);
    localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);

    state_t                state, state_n;
    logic [LOG2N-1:0]      cnt, cnt_n;
    logic [LOG2N-1:0]      pcnt, pcnt_n;
    logic [LOG2N-1:0]      idx;
    logic                  flush_pend, flush_pend_n;
    logic                  pend_eff;
    logic                  accept;
    logic                  restart;
    logic                  enable_n;
    logic                  zero_fill_n;
    logic                  out_valid_n;
    logic                  out_sop_n;
    logic                  sop_err_n;
    logic                  busy_n;
    logic [LOG2N-1:0]      ctrl_s, ctrl_n;
    logic [16*LOG2N-1:0]   addr_s, address_n;

    // A frame start restarts indexing from IDLE, or anywhere in FILL/RUN when it arrives off-boundary.
    assign restart = in_valid && in_sop &&
                     ((state == IDLE) || (((state == FILL) || (state == RUN)) && (cnt != '0)));
    assign idx      = restart ? '0 : cnt;
    assign pend_eff = flush_pend | flush;

    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        localparam logic [LOG2N-1:0] DS    = LOG2N'(FFT_N - (FFT_N >> s));
        localparam logic [LOG2N-1:0] LMASK = LOG2N'((FFT_N >> (s + 1)) - 1);
        logic [LOG2N-1:0] cnt_s;
        assign cnt_s                = idx - DS;
        assign ctrl_s[s]            = cnt_s[LOG2N-1-s];
        assign addr_s[16*s +: 16]   = 16'((cnt_s & LMASK) << s);
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        pcnt_n       = pcnt;
        flush_pend_n = flush_pend;
        accept       = 1'b0;
        out_valid_n  = 1'b0;
        zero_fill_n  = 1'b0;
        sop_err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (restart) begin
                    accept  = 1'b1;
                    state_n = FILL;
                end
            end
            FILL: begin
                flush_pend_n = pend_eff;
                if (in_valid) begin
                    accept = 1'b1;
                    if (restart) begin
                        sop_err_n = 1'b1;
                    end else if (pcnt == PRE_LAST) begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                flush_pend_n = pend_eff;
                if (in_valid) begin
                    accept = 1'b1;
                    if (restart) begin
                        sop_err_n = 1'b1;
                        state_n   = FILL;
                    end else begin
                        out_valid_n = 1'b1;
                        if ((cnt == LAST) && pend_eff) begin
                            state_n = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                accept      = 1'b1;
                out_valid_n = 1'b1;
                zero_fill_n = 1'b1;
                if (cnt == PRE_LAST) begin
                    state_n      = IDLE;
                    flush_pend_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (accept) begin
            cnt_n = idx + ONE;
        end
        if (restart) begin
            pcnt_n = ONE;
        end else if (accept && (state == FILL)) begin
            pcnt_n = pcnt + ONE;
        end

        enable_n  = accept;
        out_sop_n = out_valid_n && (idx == LAST);
        busy_n    = (state_n != IDLE);
        ctrl_n    = accept ? ctrl_s : ctrl;
        address_n = accept ? addr_s : address;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pcnt       <= '0;
            flush_pend <= 1'b0;
            enable     <= 1'b0;
            ctrl       <= '0;
            address    <= '0;
            zero_fill  <= 1'b0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            sop_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pcnt       <= pcnt_n;
            flush_pend <= flush_pend_n;
            enable     <= enable_n;
            ctrl       <= ctrl_n;
            address    <= address_n;
            zero_fill  <= zero_fill_n;
            out_valid  <= out_valid_n;
            out_sop    <= out_sop_n;
            sop_err    <= sop_err_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_fft_sdf_sequencer.sv
// Randomized and directed bench for fft_sdf_sequencer (FFT_N=16) against a frame-level
// reference model that derives stage timing from sample indices with plain arithmetic.
module tb_fft_sdf_sequencer;

    localparam int N  = 16;
    localparam int LG = 4;

    logic              clk = 1'b0;
    logic              rst_n, in_valid, in_sop, flush;
    logic              enable, zero_fill, out_valid, out_sop, sop_err, busy;
    logic [LG-1:0]     ctrl;
    logic [16*LG-1:0]  address;

    fft_sdf_sequencer #(.FFT_N(N), .LOG2N(LG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .flush(flush),
        .enable(enable), .ctrl(ctrl), .address(address), .zero_fill(zero_fill),
        .out_valid(out_valid), .out_sop(out_sop), .sop_err(sop_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: frame position, samples since sync, pending flush, drain cycles left.
    bit             m_active = 0;
    int             m_pos = 0;
    int             m_primed = 0;
    bit             m_pend = 0;
    int             m_drain = 0;
    logic           e_en, e_zf, e_ov, e_os, e_err, e_busy;
    logic [LG-1:0]  e_ctrl = '0;
    logic [16*LG-1:0] e_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_step();
        int  idx, d, cs, l;
        bit  acc, outv, err, zf;
        acc = 0; outv = 0; err = 0; zf = 0; idx = 0;
        if (!rst_n) begin
            m_active = 0; m_pos = 0; m_primed = 0; m_pend = 0; m_drain = 0;
            e_ctrl = '0; e_addr = '0;
        end else if (m_drain > 0) begin
            acc = 1; idx = m_pos; outv = 1; zf = 1;
            m_pos = (m_pos + 1) % N;
            m_drain--;
            if (m_drain == 0) begin m_active = 0; m_pend = 0; end
        end else if (!m_active) begin
            if (in_valid && in_sop) begin
                acc = 1; idx = 0; m_active = 1; m_primed = 1; m_pos = 1;
            end
        end else begin
            if (flush) m_pend = 1;
            if (in_valid) begin
                acc = 1;
                if (in_sop && m_pos != 0) begin
                    err = 1; idx = 0; m_primed = 1; m_pos = 1;
                end else begin
                    idx  = m_pos;
                    outv = (m_primed >= N - 1);
                    if (m_primed < N) m_primed++;
                    m_pos = (m_pos + 1) % N;
                    if (outv && idx == N - 1 && m_pend) m_drain = N - 1;
                end
            end
        end
        if (acc) begin
            for (int s = 0; s < LG; s++) begin
                d  = N - (N >> s);
                cs = (idx - d + N) % N;
                l  = N >> (s + 1);
                e_ctrl[s] = ((cs % (2 * l)) >= l);
                e_addr[16*s +: 16] = 16'((cs % l) << s);
            end
        end
        e_en = acc; e_ov = outv; e_os = outv && (idx == N - 1);
        e_err = err; e_zf = zf; e_busy = m_active;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("enable",    64'(enable),    64'(e_en));
        chk("ctrl",      64'(ctrl),      64'(e_ctrl));
        chk("address",   address,        e_addr);
        chk("zero_fill", 64'(zero_fill), 64'(e_zf));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("out_sop",   64'(out_sop),   64'(e_os));
        chk("sop_err",   64'(sop_err),   64'(e_err));
        chk("busy",      64'(busy),      64'(e_busy));
    endtask

    int zf_cnt;

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_sop = 1'b0; flush = 1'b0;
        @(negedge clk);
        repeat (3) cycle();
        rst_n = 1'b1; in_valid = 1'b0;
        cycle();

        // Two contiguous frames, second sop on the boundary.
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_sop = (i == 0) || (i == 16);
            cycle();
        end
        in_valid = 1'b0; in_sop = 1'b0;
        cycle();

        for (int i = 0; i < 16; i++) begin
            in_valid = (i % 2) == 0;
            cycle();
        end

        // Misplaced sop at index 5.
        in_valid = 1'b1;
        for (int i = 0; i < 64 && m_pos != 5; i++) cycle();
        chk("reach_idx5", 64'(m_pos), 64'd5);
        in_sop = 1'b1;
        cycle();
        in_sop = 1'b0;
        repeat (20) cycle();

        // Flush at index 3 in RUN, then count zero-fill cycles of the drain.
        for (int i = 0; i < 64 && !(m_pos == 3 && m_primed >= N - 1); i++) cycle();
        chk("reach_idx3", 64'(m_pos), 64'd3);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        zf_cnt = 0;
        for (int i = 0; i < 100 && m_active; i++) begin
            cycle();
            if (zero_fill) zf_cnt++;
        end
        chk("drain_len", 64'(zf_cnt), 64'(N - 1));
        chk("idle_after_drain", 64'(busy), 64'd0);
        repeat (4) cycle();

        for (int i = 0; i < 4000; i++) begin
            rst_n    = ($urandom_range(0, 799) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            if (!m_active)      in_sop = ($urandom_range(0, 3) == 0);
            else if (m_pos == 0) in_sop = $urandom_range(0, 1) != 0;
            else                in_sop = ($urandom_range(0, 59) == 0);
            flush    = ($urandom_range(0, 149) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
